tone_synth: RTL and testbench

//  Sample-rate tone generator between the note datapath (freq_out) and the audio codec serializer.

---
 rtl/tone_synth.sv | 175 +++++++++++++++++
 tb/tb_tone_synth.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tone_synth.sv
// Sample-rate tone generator: phase accumulator, selectable waveform and an
// attack/sustain/release envelope. It produces signed 16-bit PCM on a valid/ready handshake.
module tone_synth #(
    parameter int unsigned SAMPLE_DIV   = 1042,
    parameter int unsigned ATTACK_STEP  = 4,
    parameter int unsigned RELEASE_STEP = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] freq,
    input  logic [1:0]  wave_sel,
    input  logic        sample_ready,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned CntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SAMPLE_DIV - 1);
    localparam logic [8:0] AttStep = 9'(ATTACK_STEP);
    localparam logic [7:0] RelStep = 8'(RELEASE_STEP);

    typedef enum logic [1:0] {
        StIdle,
        StAttack,
        StSustain,
        StRelease
    } env_state_e;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     phase_q, phase_d;
    logic [31:0]     inc_q, inc_d;
    logic [7:0]      env_q, env_d;
    env_state_e      state_q, state_d;
    logic [15:0]     data_q, data_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;

    logic               tick;
    logic               retrig;
    logic [14:0]        tri_t;
    logic [15:0]        raw;
    logic signed [24:0] raw_ext;
    logic signed [24:0] env_ext;
    logic signed [24:0] prod;
    logic [15:0]        scaled;
    logic [8:0]         env_sum;
    logic [7:0]         env_att;
    logic [7:0]         env_rel;
    logic               unused_prod;

    assign tick   = (cnt_q == CntMax);
    assign retrig = (freq != 32'd0) && (freq != inc_q);

    // Raw waveform from the current phase, then scale by the envelope.
    always_comb begin
        tri_t = phase_q[31] ? ~phase_q[30:16] : phase_q[30:16];
        raw   = 16'h0000;
        unique case (wave_sel)
            2'd0:    raw = phase_q[31] ? 16'h8001 : 16'h7FFF;
            2'd1:    raw = {~phase_q[31], phase_q[30:16]};
            2'd2:    raw = {~tri_t[14], tri_t[13:0], 1'b0};
            default: raw = 16'h0000;
        endcase
        raw_ext = 25'($signed(raw));
        env_ext = $signed({17'd0, env_q});
        prod    = raw_ext * env_ext;
        // Bits [23:8] give an arithmetic shift right by 8 (floor).
        scaled  = prod[23:8];
    end

    assign unused_prod = ^{prod[24], prod[7:0]};

    // Saturating envelope step values for attack and release.
    always_comb begin
        env_sum = {1'b0, env_q} + AttStep;
        env_att = (env_sum > 9'd255) ? 8'hFF : env_sum[7:0];
        env_rel = (env_q > RelStep) ? (env_q - RelStep) : 8'd0;
    end

    // Next-state logic: sample divider, handshake, accumulator and envelope FSM.
    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        phase_d   = phase_q;
        inc_d     = inc_q;
        env_d     = env_q;
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end

        if (tick) begin
            // A new sample always wins over a same-cycle acceptance.
            data_d  = scaled;
            valid_d = 1'b1;
            if (valid_q && !sample_ready) begin
                overrun_d = 1'b1;
            end
            phase_d = phase_q + inc_q;

            if (retrig) begin
                // Retrigger keeps env so a new note does not click down to zero.
                inc_d   = freq;
                phase_d = 32'd0;
                state_d = StAttack;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        env_d = 8'd0;
                    end
                    StAttack: begin
                        if (freq == 32'd0) begin
                            state_d = StRelease;
                        end else begin
                            env_d = env_att;
                            if (env_att == 8'hFF) begin
                                state_d = StSustain;
                            end
                        end
                    end
                    StSustain: begin
                        if (freq == 32'd0) begin
                            state_d = StRelease;
                        end
                    end
                    StRelease: begin
                        env_d = env_rel;
                        if (env_rel == 8'd0) begin
                            state_d = StIdle;
                            inc_d   = 32'd0;
                            phase_d = 32'd0;
                        end
                    end
                    default: begin
                        state_d = StIdle;
                    end
                endcase
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            phase_q   <= 32'd0;
            inc_q     <= 32'd0;
            env_q     <= 8'd0;
            state_q   <= StIdle;
            data_q    <= 16'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            inc_q     <= inc_d;
            env_q     <= env_d;
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth with SAMPLE_DIV=4, ATTACK_STEP=64, RELEASE_STEP=255.
module tb_tone_synth;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] freq;
    logic [1:0]  wave_sel;
    logic        sample_ready;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        busy;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    tone_synth #(
        .SAMPLE_DIV  (4),
        .ATTACK_STEP (64),
        .RELEASE_STEP(255)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .freq        (freq),
        .wave_sel    (wave_sel),
        .sample_ready(sample_ready),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Advance to just after the next tick edge (caller stays tick-aligned).
    task automatic tick_sample();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        freq         = 32'd0;
        wave_sel     = 2'd0;
        sample_ready = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", sample_valid);
        end
        checks++;
        if (sample_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: got %h want 0000", sample_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_overrun: got %b want 0", overrun);
        end
        // Idle samples: one-cycle valid pulse every 4 cycles, data 0.
        tick_sample();
        checks++;
        if (sample_valid !== 1'b1 || sample_data !== 16'h0000) begin
            errors++;
            $display("FAIL idle_tick1: valid=%b data=%h want 1/0000", sample_valid, sample_data);
        end
        cycle();
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_accept: valid=%b want 0", sample_valid);
        end
        repeat (3) cycle();
        checks++;
        if (sample_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_tick2: valid=%b busy=%b want 1/0", sample_valid, busy);
        end
    endtask

    // Square attack ramp: T0 retrigger, then env 64/128/192/255 and sustain.
    task automatic test_attack();
        logic [15:0] exp_data [9];
        exp_data = '{16'h0000, 16'h0000, 16'h1FFF, 16'hC000, 16'hA000,
                     16'h7F7F, 16'h7F7F, 16'h8080, 16'h8080};
        freq     = 32'h4000_0000;
        wave_sel = 2'd0;
        for (int i = 0; i < 9; i++) begin
            tick_sample();
            checks++;
            if (sample_data !== exp_data[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL attack_T%0d: data=%h busy=%b want %h/1",
                         i, sample_data, busy, exp_data[i]);
            end
        end
    endtask

    // Saw, triangle and silence at env 255 across phases 0, 4, 8, C, 0 (x 2^28).
    task automatic test_waveforms();
        logic [1:0]  waves [5];
        logic [15:0] exp_data [5];
        waves    = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
        exp_data = '{16'h8080, 16'hC040, 16'h0000, 16'hFFFE, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            wave_sel = waves[i];
            tick_sample();
            checks++;
            if (sample_data !== exp_data[i]) begin
                errors++;
                $display("FAIL wave_%0d_step%0d: data=%h want %h",
                         waves[i], i, sample_data, exp_data[i]);
            end
        end
    endtask

    task automatic test_overrun();
        wave_sel     = 2'd0;
        sample_ready = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_before: got %b want 0", overrun);
        end
        tick_sample();
        checks++;
        if (sample_valid !== 1'b1 || sample_data !== 16'h7F7F || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: valid=%b data=%h ovr=%b want 1/7f7f/1",
                     sample_valid, sample_data, overrun);
        end
        sample_ready = 1'b1;
        cycle();
        checks++;
        if (sample_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_accept: valid=%b ovr=%b want 0/1", sample_valid, overrun);
        end
        repeat (3) cycle();
        checks++;
        if (sample_data !== 16'h8080 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: data=%h ovr=%b want 8080/1", sample_data, overrun);
        end
    endtask

    // Note off from sustain: RELEASE, then env reaches 0 and the FSM idles.
    task automatic test_release();
        logic [15:0] exp_data [4];
        logic        exp_busy [4];
        exp_data = '{16'h8080, 16'h7F7F, 16'h0000, 16'h0000};
        exp_busy = '{1'b1, 1'b0, 1'b0, 1'b0};
        freq = 32'd0;
        for (int i = 0; i < 4; i++) begin
            tick_sample();
            checks++;
            if (sample_data !== exp_data[i] || busy !== exp_busy[i]) begin
                errors++;
                $display("FAIL release_T%0d: data=%h busy=%b want %h/%b",
                         i, sample_data, busy, exp_data[i], exp_busy[i]);
            end
        end
    endtask

    // Reset one cycle before a tick while in ATTACK with a pending unaccepted sample.
    task automatic test_reset_mid();
        freq = 32'h2000_0000;
        tick_sample();
        tick_sample();
        tick_sample();
        checks++;
        if (sample_data !== 16'h1FFF || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_attack: data=%h busy=%b want 1fff/1", sample_data, busy);
        end
        sample_ready = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        checks++;
        if (sample_valid !== 1'b0 || sample_data !== 16'h0000 || busy !== 1'b0 ||
            overrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b data=%h busy=%b ovr=%b want all 0",
                     sample_valid, sample_data, busy, overrun);
        end
        reset        = 1'b0;
        freq         = 32'd0;
        sample_ready = 1'b1;
        repeat (3) cycle();
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_restart_early: valid=%b want 0", sample_valid);
        end
        cycle();
        checks++;
        if (sample_valid !== 1'b1 || sample_data !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_restart_tick: valid=%b data=%h busy=%b want 1/0000/0",
                     sample_valid, sample_data, busy);
        end
    endtask

    initial begin
        test_reset();
        test_attack();
        test_waveforms();
        test_overrun();
        test_release();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
